// File: rtl/uartin_pkg.sv
// uartin shared definitions: FSM state codes and clock constants
// used to derive the bit period from the system clock and baud rate.
package uartin_pkg;

    localparam int CYCLE_CLK_HZ  = 50_000_000;
    localparam int CYCLE_BAUD    = 115_200;
    localparam int CYCLE_PER_BIT = CYCLE_CLK_HZ / CYCLE_BAUD;

    localparam int NBITS = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;

endpackage

// File: rtl/uartin_if.sv
// uartin FIFO write port: active-low strobe, active-low full status.
// master = receiver side, slave = FIFO side.
interface uartin_if;

    logic [7:0] port;
    logic       n_wr;
    logic       n_full;

    modport master (
        output port,
        output n_wr,
        input  n_full
    );

    modport slave (
        input  port,
        input  n_wr,
        output n_full
    );

endinterface

// File: rtl/uart_sync.sv
// uartin rx synchroniser: STAGES-deep flop chain, idles (and resets)
// to 1 so a reset never looks like a start bit.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw line in at the bottom of the chain
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // chain registers, line-idle value on reset
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uartin.sv
// uartin: 8N1 UART receiver feeding a FIFO through an active-low
// write strobe; flags framing errors and FIFO overruns.
module uartin
    import uartin_pkg::*;
#(
    parameter int CDIV        = CYCLE_PER_BIT,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    input  logic      clr,
    uartin_if.master  fifo,
    output logic      ferr,
    output logic      ovr,
    output logic [1:0] sticky
);

    localparam int CW = $clog2(CDIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CDIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CDIV - 1);

    logic          rxs;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    port_q, port_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic [1:0]    sticky_q, sticky_d;
    logic          wr_fire;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    // frame FSM: mid-bit sampling, byte assembly, write/flag decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        port_d  = port_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        wr_fire = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'(NBITS - 1)) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = S_WRITE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = S_IDLE;
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
                if (fifo.n_full) begin
                    wr_fire = 1'b1;
                    port_d  = shift_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        sticky_d = (clr ? 2'b00 : sticky_q) | {ovr_d, ferr_d};
    end

    // state, datapath and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            port_q   <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            port_q   <= port_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            sticky_q <= sticky_d;
        end
    end

    assign fifo.port = wr_fire ? shift_q : port_q;
    assign fifo.n_wr = ~wr_fire;
    assign ferr      = ferr_q;
    assign ovr       = ovr_q;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_uartin.sv
// uartin bench: directed and random 8N1 frames against a frame-level
// scoreboard of expected bytes, error counts and sticky bits.
module tb_uartin;

    localparam int CDIV = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + CDIV / 2 + 9 * CDIV + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       clr;
    logic       ferr;
    logic       ovr;
    logic [1:0] sticky;

    uartin_if fifo_if ();

    uartin #(
        .CDIV        (CDIV),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .clr    (clr),
        .fifo   (fifo_if),
        .ferr   (ferr),
        .ovr    (ovr),
        .sticky (sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         wide_cnt  = 0;
    logic       prev_nwr  = 1'b1;

    logic [7:0] exp_q[$];
    int         exp_ferr   = 0;
    int         exp_ovr    = 0;
    logic [1:0] exp_sticky = 2'b00;
    logic [7:0] exp_port   = 8'h00;
    int         last_c0    = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // observe the FIFO side and the error pulses
    always @(negedge clk) begin
        if (fifo_if.n_wr === 1'b0) begin
            got_q.push_back(fifo_if.port);
            got_cyc.push_back(cyc);
            if (prev_nwr === 1'b0) wide_cnt++;
        end
        prev_nwr = fifo_if.n_wr;
        if (ferr === 1'b1) ferr_cnt++;
        if (ovr === 1'b1) ovr_cnt++;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        last_c0 = cyc;
        rx = 1'b0;
        repeat (CDIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CDIV) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CDIV) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic good,
                               input logic nf);
        if (!good) begin
            exp_ferr++;
            exp_sticky[0] = 1'b1;
        end else if (nf) begin
            exp_q.push_back(b);
            exp_port = b;
        end else begin
            exp_ovr++;
            exp_sticky[1] = 1'b1;
        end
    endtask

    task automatic sb(input string tag);
        logic [7:0] g;
        logic [7:0] e;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_byte"}, {24'h0, g}, {24'h0, e});
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
        chk({tag, "_ovr"}, ovr_cnt, exp_ovr);
        chk({tag, "_sticky"}, {30'h0, sticky}, {30'h0, exp_sticky});
        chk({tag, "_port"}, {24'h0, fifo_if.port}, {24'h0, exp_port});
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_sticky = 2'b00;
    endtask

    initial begin
        logic [7:0] b;
        logic       nf;
        logic       good;
        logic [7:0] a5;

        rst = 1'b1;
        rx  = 1'b1;
        clr = 1'b0;
        fifo_if.n_full = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_port", {24'h0, fifo_if.port}, 32'h00);
        chk("rst_nwr", {31'h0, fifo_if.n_wr}, 32'h1);
        chk("rst_ferr", {31'h0, ferr}, 32'h0);
        chk("rst_ovr", {31'h0, ovr}, 32'h0);
        chk("rst_sticky", {30'h0, sticky}, 32'h0);
        rst = 1'b0;
        idle(4);

        send(8'h41, 1'b1);
        model_frame(8'h41, 1'b1, 1'b1);
        idle(2 * CDIV);
        chk("a_strobes", got_cyc.size(), 1);
        if (got_cyc.size() > 0)
            chk("a_latency", got_cyc[0] - last_c0, LAT);
        sb("a");

        send(8'h00, 1'b1);
        model_frame(8'h00, 1'b1, 1'b1);
        send(8'hFF, 1'b1);
        model_frame(8'hFF, 1'b1, 1'b1);
        idle(2 * CDIV);
        sb("b2b");

        send(8'h55, 1'b0);
        model_frame(8'h55, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(2 * CDIV);
        sb("ferr");
        send(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1, 1'b1);
        idle(2 * CDIV);
        sb("after_ferr");
        pulse_clr();
        chk("clr1_sticky", {30'h0, sticky}, 32'h0);

        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(4 * CDIV);
        sb("glitch");

        fifo_if.n_full = 1'b0;
        send(8'h7A, 1'b1);
        model_frame(8'h7A, 1'b1, 1'b0);
        idle(2 * CDIV);
        sb("ovr");
        fifo_if.n_full = 1'b1;
        pulse_clr();
        chk("clr2_sticky", {30'h0, sticky}, 32'h0);

        a5 = 8'hA5;
        rx = 1'b0;
        repeat (CDIV) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx = a5[i];
            repeat (CDIV) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_port", {24'h0, fifo_if.port}, 32'h00);
            chk("mrst_nwr", {31'h0, fifo_if.n_wr}, 32'h1);
            chk("mrst_flags", {29'h0, ferr, ovr, |sticky}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sticky = 2'b00;
        exp_port   = 8'h00;
        idle(2 * CDIV);
        send(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b1);
        idle(2 * CDIV);
        sb("mrst");

        for (int k = 0; k < 14; k++) begin
            b    = 8'($urandom);
            nf   = ($urandom_range(0, 3) != 0);
            good = ($urandom_range(0, 5) != 0);
            fifo_if.n_full = nf;
            send(b, good);
            model_frame(b, good, nf);
            if (!good) begin
                rx = 1'b0;
                repeat ($urandom_range(CDIV, 4 * CDIV)) @(posedge clk);
                #1;
                idle(2 * CDIV);
            end else begin
                idle($urandom_range(0, 2 * CDIV));
            end
            chk("rnd_sticky", {30'h0, sticky}, {30'h0, exp_sticky});
            if ($urandom_range(0, 3) == 0) begin
                idle(4);
                pulse_clr();
            end
        end
        fifo_if.n_full = 1'b1;
        idle(2 * CDIV);
        sb("rand");

        chk("nwr_width", wide_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
